izhikevich_array: RTL and testbench
===================================

Name: izhikevich_array

Overview:
- Time-multiplexed bank of NUM_NEURONS Izhikevich neurons sharing one fixed-point datapath.
- Per-neuron voltage/recovery state lives in internal register files.
- A start pulse sweeps every neuron once (one Euler step each), then reports a spike vector and a done pulse.
- Successor to the single-neuron core: scales to a neuron count, saturates arithmetic, and adds an init/readback port and a busy/done handshake.

Parameters:
- N, 24, total signed fixed-point word width.
- Q, 8, fractional bits.
- NUM_NEURONS, 4, neurons in the bank (>=1).
- IDX_W, $clog2(NUM_NEURONS) (min 1), index width.
- CNT_W, 16, spike counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one sweep; accepted only in IDLE.
- i_bus  in  N*NUM_NEURONS  per-neuron input current; neuron k at [k*N +: N]; latched on start acceptance.
- a, b, c, d, v_th, dv_step, dw_step  in  N each  shared model constants, Q format; must be stable while busy.
- init_we  in  1  write initial state; honoured only in IDLE.
- init_idx  in  IDX_W  target neuron for init write / readback.
- v_init, w_init  in  N each  values written on init_we.
- busy  out  1  high from cycle after start acceptance until DONE completes.
- done  out  1  one-cycle pulse, sweep complete.
- spikes  out  NUM_NEURONS  bit k = neuron k fired in last sweep; valid from done until next start acceptance.
- spike_count  out  CNT_W  total spikes since reset, saturating.
- rd_voltage, rd_w  out  N each  combinational readback of neuron init_idx.

Behaviour:
- Reset (async, rst_n=0): all voltage/w entries=0, state=IDLE, busy=0, done=0, spikes=0, spike_count=0, index=0. Reset mid-sweep aborts immediately; partial writes already committed are cleared.
- FSM: IDLE -> EVAL -> COMMIT -> (EVAL | DONE) -> IDLE.
- IDLE: start=1 latches i_bus, clears spikes, idx<=0, goes to EVAL. If init_we and start arrive together, the init write happens first, same edge, and the sweep uses the new value.
- EVAL (1 cycle): read v,w of neuron idx; compute
  - dv = dv_step*(0.04v^2 + 5v + 140 - w + i)
  - dw = dw_step*(a*(b*v - w))
  - All products are full-width, arithmetic-shifted right by Q, truncated toward -inf. Constants 0.04, 5 and 140 are encoded in Q format.
  - Register fire = ($signed(v) > $signed(v_th)), strict compare on the pre-update v.
- COMMIT (1 cycle):
  - If fire: v<=c, w<=w+d, spikes[idx]<=1, spike_count+=1 (holds at all-ones).
  - Else: v<=v+dv, w<=w+dw.
  - All adds saturate to [-2^(N-1), 2^(N-1)-1]; no wrap-around.
  - If idx==NUM_NEURONS-1 go DONE, else idx++ and go EVAL.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is high in cycle 2*NUM_NEURONS+1 after the start-accept edge.
- busy=1 in EVAL, COMMIT, DONE.
- start while busy: ignored, not queued.
- init_we while busy: ignored, no state change.
- Intermediate squares must not overflow before shifting; size the multipliers at 2N.

Test Plan:
- Reset/readback: assert rst_n=0 mid-sweep with NUM_NEURONS=4 -> busy=0, done=0, spikes=0, spike_count=0, rd_voltage=rd_w=0 for all idx, asynchronously without a clock edge.
- Rest step, Q8: init neuron 0 v=0, w=0; i=0; dv_step=256 (1.0); a=b=0 -> after done, rd_voltage(0)=35840 (140.0), rd_w(0)=0, spikes=0.
- Spike: v_th=7680 (30.0); neuron 2 v_init=7936 (31.0), w_init=512; c=-16640 (-65.0); d=2048 -> neuron 2 v=-16640, w=2560, spikes=4'b0100, spike_count=1. Repeat with v_init=7680 -> no spike (strict >).
- Latency/handshake: NUM_NEURONS=4, pulse start -> done exactly 9 cycles later, busy high throughout. A second start at cycle 3 is ignored (one done only). init_we at cycle 5 leaves state unchanged.
- Saturation: v_init=0x7F0000, i=0x400000 -> v=0x7FFFFF (no wrap to negative). Negative analogue clamps to 0x800000.
- Counter saturation, CNT_W=2: force a spike on every neuron over 2 sweeps (8 spikes) -> spike_count holds 3.

Source files
------------

// File: rtl/izhikevich_array.sv
// Time-multiplexed bank of Izhikevich neurons sharing one saturating fixed-point
// datapath; a start pulse sweeps every neuron once and reports a spike vector.
module izhikevich_array #(
  parameter int N           = 24,
  parameter int Q           = 8,
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N*NUM_NEURONS-1:0] i_bus,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic [N-1:0]             c,
  input  logic [N-1:0]             d,
  input  logic [N-1:0]             v_th,
  input  logic [N-1:0]             dv_step,
  input  logic [N-1:0]             dw_step,
  input  logic                     init_we,
  input  logic [IDX_W-1:0]         init_idx,
  input  logic [N-1:0]             v_init,
  input  logic [N-1:0]             w_init,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_NEURONS-1:0]   spikes,
  output logic [CNT_W-1:0]         spike_count,
  output logic [N-1:0]             rd_voltage,
  output logic [N-1:0]             rd_w
);

  // Wide enough that the nested dw product chain never overflows before saturation.
  localparam int WW = 4 * N;
  typedef logic signed [WW-1:0] wide_t;
  typedef logic signed [N-1:0]  word_t;

  localparam wide_t K004    = wide_t'((4 * (2 ** Q)) / 100);
  localparam wide_t K5      = wide_t'(5 * (2 ** Q));
  localparam wide_t K140    = wide_t'(140 * (2 ** Q));
  localparam wide_t SAT_MAX = (wide_t'(1) <<< (N - 1)) - wide_t'(1);
  localparam wide_t SAT_MIN = -(wide_t'(1) <<< (N - 1));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  word_t            v_mem [NUM_NEURONS];
  word_t            w_mem [NUM_NEURONS];
  word_t            i_lat [NUM_NEURONS];
  logic             fire_q;
  word_t            v_nxt_q, w_nxt_q;

  function automatic wide_t sx(input word_t x);
    return wide_t'(x);
  endfunction

  // Floor semantics: arithmetic shift truncates toward -inf.
  function automatic wide_t qmul(input wide_t x, input wide_t y);
    return (x * y) >>> Q;
  endfunction

  function automatic word_t sat(input wide_t x);
    if (x > SAT_MAX) return word_t'(SAT_MAX);
    if (x < SAT_MIN) return word_t'(SAT_MIN);
    return word_t'(x);
  endfunction

  wide_t vx, wx, ix, sq, sum, dv, bv, dw;
  word_t v_upd, w_upd, w_fire;
  logic  fire;

  always_comb begin
    vx     = sx(v_mem[idx_q]);
    wx     = sx(w_mem[idx_q]);
    ix     = sx(i_lat[idx_q]);
    sq     = qmul(vx, vx);
    sum    = qmul(K004, sq) + qmul(K5, vx) + K140 - wx + ix;
    dv     = qmul(sx(word_t'(dv_step)), sum);
    bv     = qmul(sx(word_t'(b)), vx);
    dw     = qmul(sx(word_t'(dw_step)), qmul(sx(word_t'(a)), bv - wx));
    v_upd  = sat(vx + dv);
    w_upd  = sat(wx + dw);
    w_fire = sat(wx + sx(word_t'(d)));
    fire   = $signed(v_mem[idx_q]) > $signed(v_th);
  end

  // Handshake: start is taken only in IDLE; busy covers EVAL..DONE; done is a
  // single-cycle pulse after which spikes stays valid until the next accepted start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = COMMIT;
      COMMIT:  state_d = (idx_q == LAST) ? DONE : EVAL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fire_q      <= 1'b0;
      v_nxt_q     <= '0;
      w_nxt_q     <= '0;
      spikes      <= '0;
      spike_count <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k] <= '0;
        w_mem[k] <= '0;
        i_lat[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // Init write lands on the same edge as start, so the sweep sees it.
          if (init_we && (32'(init_idx) < NUM_NEURONS)) begin
            v_mem[init_idx] <= v_init;
            w_mem[init_idx] <= w_init;
          end
          if (start) begin
            for (int k = 0; k < NUM_NEURONS; k++) i_lat[k] <= i_bus[k*N +: N];
            spikes <= '0;
            idx_q  <= '0;
          end
        end
        EVAL: begin
          fire_q  <= fire;
          v_nxt_q <= fire ? word_t'(c) : v_upd;
          w_nxt_q <= fire ? w_fire : w_upd;
        end
        COMMIT: begin
          v_mem[idx_q] <= v_nxt_q;
          w_mem[idx_q] <= w_nxt_q;
          if (fire_q) begin
            spikes[idx_q] <= 1'b1;
            if (spike_count != '1) spike_count <= spike_count + CNT_W'(1);
          end
          if (idx_q != LAST) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_voltage = '0;
    rd_w       = '0;
    if (32'(init_idx) < NUM_NEURONS) begin
      rd_voltage = v_mem[init_idx];
      rd_w       = w_mem[init_idx];
    end
  end

endmodule

// File: tb/tb_izhikevich_array.sv
// Directed bench for izhikevich_array: table of single-sweep vectors plus
// handshake, counter-saturation and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_izhikevich_array;

  localparam int N  = 24;
  localparam int NN = 4;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            start, init_we;
  logic [N*NN-1:0] i_bus;
  logic [N-1:0]    a, b, c, d, v_th, dv_step, dw_step, v_init, w_init;
  logic [IW-1:0]   init_idx;

  logic            busy, done, busy2, done2;
  logic [NN-1:0]   spikes, spikes2;
  logic [15:0]     spike_count;
  logic [1:0]      count2;
  logic [N-1:0]    rd_voltage, rd_w, rdv2, rdw2;

  izhikevich_array #(.N(N), .Q(8), .NUM_NEURONS(NN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i_bus(i_bus),
    .a(a), .b(b), .c(c), .d(d), .v_th(v_th), .dv_step(dv_step), .dw_step(dw_step),
    .init_we(init_we), .init_idx(init_idx), .v_init(v_init), .w_init(w_init),
    .busy(busy), .done(done), .spikes(spikes), .spike_count(spike_count),
    .rd_voltage(rd_voltage), .rd_w(rd_w)
  );

  izhikevich_array #(.N(N), .Q(8), .NUM_NEURONS(NN), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .start(start), .i_bus(i_bus),
    .a(a), .b(b), .c(c), .d(d), .v_th(v_th), .dv_step(dv_step), .dw_step(dw_step),
    .init_we(init_we), .init_idx(init_idx), .v_init(v_init), .w_init(w_init),
    .busy(busy2), .done(done2), .spikes(spikes2), .spike_count(count2),
    .rd_voltage(rdv2), .rd_w(rdw2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_count"}, 32'(spike_count), 32'(exp_count));
    check({tag, "_count_c2"}, 32'(count2), (exp_count > 3) ? 32'd3 : 32'(exp_count));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    logic [N-1:0] v0, w0, i0, ka, kb, kc, kd, vth, dvs, dws, ev, ew;
    bit         fire;
  } vec_t;

  function automatic vec_t mk(input int idx, input int v0, input int w0, input int i0,
                              input int ka, input int kb, input int kc, input int kd,
                              input int vth, input int dvs, input int dws,
                              input int ev, input int ew, input bit fire);
    vec_t r;
    r.idx = idx;  r.v0 = N'(v0);   r.w0 = N'(w0);   r.i0 = N'(i0);
    r.ka = N'(ka); r.kb = N'(kb);  r.kc = N'(kc);   r.kd = N'(kd);
    r.vth = N'(vth); r.dvs = N'(dvs); r.dws = N'(dws);
    r.ev = N'(ev); r.ew = N'(ew);  r.fire = fire;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_consts(input logic [N-1:0] ka, kb, kc, kd, vth, dvs, dws);
    a = ka; b = kb; c = kc; d = kd; v_th = vth; dv_step = dvs; dw_step = dws;
  endtask

  task automatic init_neuron(input int k, input logic [N-1:0] v, input logic [N-1:0] w);
    init_idx = IW'(k); v_init = v; w_init = w; init_we = 1'b1;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // Returns at the negedge where done is seen (lat counts cycles after accept).
  task automatic run_sweep(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("sweep_timeout", 32'(done), 32'd1);
  endtask

  vec_t vecs[9];
  int   lat;

  initial begin
    vecs[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7680, 256, 256, 35840, 0, 0);
    vecs[1] = mk(2, 7936, 512, 0, 0, 0, -16640, 2048, 7680, 256, 256, -16640, 2560, 1);
    vecs[2] = mk(2, 7680, 512, 0, 0, 0, -16640, 2048, 7680, 256, 256, 90408, 512, 0);
    vecs[3] = mk(1, 256, 0, 0, 128, 64, 0, 0, 7680, 0, 256, 256, 32, 0);
    vecs[4] = mk(3, 0, 256, 1280, 0, 0, 0, 0, 7680, 128, 256, 18432, 256, 0);
    vecs[5] = mk(1, 0, 0, -35841, 0, 0, 0, 0, 7680, 128, 256, -1, 0, 0);
    vecs[6] = mk(0, 'h7F0000, 0, 'h400000, 0, 0, 0, 0, 'h7FFFFF, 256, 0, 'h7FFFFF, 0, 0);
    vecs[7] = mk(3, 0, 'h7FFFFF, 'h800000, 0, 0, 0, 0, 'h7FFFFF, 256, 0, 'h800000, 'h7FFFFF, 0);
    vecs[8] = mk(0, 7936, 'h7FF000, 0, 0, 0, -16640, 'h10000, 7680, 256, 256, -16640, 'h7FFFFF, 1);

    rst_n = 1'b0; start = 1'b0; init_we = 1'b0; init_idx = '0;
    v_init = '0; w_init = '0; i_bus = '0;
    set_consts('0, '0, '0, '0, '0, '0, '0);

    // Reset state, sampled before the first clock edge.
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spikes", 32'(spikes), 32'd0);
    check("rst_rd_v", 32'(rd_voltage), 32'd0);
    check_counts("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- table-driven single sweeps ----------------
    for (int t = 0; t < 9; t++) begin
      set_consts(vecs[t].ka, vecs[t].kb, vecs[t].kc, vecs[t].kd,
                 vecs[t].vth, vecs[t].dvs, vecs[t].dws);
      i_bus = '0;
      i_bus[vecs[t].idx*N +: N] = vecs[t].i0;
      for (int k = 0; k < NN; k++) begin
        if (k == vecs[t].idx) init_neuron(k, vecs[t].v0, vecs[t].w0);
        else                  init_neuron(k, '0, '0);
      end
      exp_q.push_back(vecs[t].ev);
      exp_q.push_back(vecs[t].ew);
      run_sweep(lat);
      check($sformatf("v%0d_latency", t), 32'(lat), 32'd9);
      check($sformatf("v%0d_spikes", t), 32'(spikes),
            vecs[t].fire ? (32'd1 << vecs[t].idx) : 32'd0);
      if (vecs[t].fire) exp_count++;
      check_counts($sformatf("v%0d", t));
      @(negedge clk);
      init_idx = IW'(vecs[t].idx);
      #1;
      check($sformatf("v%0d_rd_v", t), 32'(rd_voltage), 32'(exp_q.pop_front()));
      check($sformatf("v%0d_rd_w", t), 32'(rd_w), 32'(exp_q.pop_front()));
      @(negedge clk);
    end

    // ---------------- handshake: ignored start and init_we while busy ----------------
    begin
      int  first_done, ndone, busy10;
      bit  all_busy;
      set_consts('0, '0, '0, '0, N'(7680), N'(256), N'(256));
      i_bus = '0;
      for (int k = 0; k < NN; k++) init_neuron(k, '0, '0);
      first_done = 0; ndone = 0; busy10 = -1; all_busy = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
        if (done) begin
          ndone++;
          if (first_done == 0) first_done = cyc;
        end
        if (cyc <= 9 && !busy) all_busy = 1'b0;
        if (cyc == 10) busy10 = int'(busy);
        start    = (cyc == 3);
        init_we  = (cyc == 5);
        init_idx = '0; v_init = N'(123); w_init = N'(77);
        @(negedge clk);
      end
      start = 1'b0; init_we = 1'b0;
      check("hs_first_done", 32'(first_done), 32'd9);
      check("hs_done_count", 32'(ndone), 32'd1);
      check("hs_busy_held", 32'(all_busy), 32'd1);
      check("hs_busy_after", 32'(busy10), 32'd0);
      init_idx = '0;
      #1;
      check("hs_rd_v0", 32'(rd_voltage), 32'd35840);
      check("hs_rd_w0", 32'(rd_w), 32'd0);
      @(negedge clk);
    end

    // ---------------- spike counter saturation (CNT_W=2 instance) ----------------
    set_consts('0, '0, N'(-16640), '0, N'(7680), N'(256), N'(256));
    i_bus = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < NN; k++) init_neuron(k, N'(7936), '0);
      run_sweep(lat);
      check($sformatf("sat%0d_spikes", s), 32'(spikes), 32'hF);
      exp_count += 4;
      check_counts($sformatf("sat%0d", s));
      @(negedge clk);
    end

    // ---------------- asynchronous reset mid-sweep ----------------
    for (int k = 0; k < NN; k++) init_neuron(k, N'(7936), '0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_spikes", 32'(spikes), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_spikes", 32'(spikes), 32'd0);
    check_counts("mrst");
    for (int k = 0; k < NN; k++) begin
      init_idx = IW'(k);
      #1;
      check($sformatf("mrst_rd_v%0d", k), 32'(rd_voltage), 32'd0);
      check($sformatf("mrst_rd_w%0d", k), 32'(rd_w), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
